// File: rtl/conn_lookup_arb.sv
// Round-robin arbiter sharing one connection-table lookup engine between RX and TX requesters.
// Optional WAIT timeout with error response: define LOOKUP_TIMEOUT_EN.
module conn_lookup_arb #(
   parameter int TUPLE_W = 128,
   parameter int CONN_W  = 16,
   parameter int TIMEOUT = 255
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [TUPLE_W-1:0] rx_tuple_data,
   input  logic               rx_tuple_valid,
   output logic               rx_tuple_ready,
   output logic [CONN_W-1:0]  rx_conn_data,
   output logic               rx_conn_valid,
   output logic               rx_conn_err,
   input  logic [TUPLE_W-1:0] tx_tuple_data,
   input  logic               tx_tuple_valid,
   output logic               tx_tuple_ready,
   output logic [CONN_W-1:0]  tx_conn_data,
   output logic               tx_conn_valid,
   output logic               tx_conn_err,
   output logic [TUPLE_W-1:0] eng_tuple_data,
   output logic               eng_sel,
   output logic               eng_tuple_valid,
   input  logic               eng_tuple_ready,
   input  logic [CONN_W-1:0]  eng_conn_data,
   input  logic               eng_conn_valid,
   output logic               busy
);

   // state | meaning
   // IDLE  | arbitrate, accept one tuple
   // ISSUE | present tuple to engine until accepted
   // WAIT  | wait for engine result (or timeout)
   // RESP  | one-cycle result strobe to owner
   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

   state_t state, state_nxt;
   logic   last_grant;
   logic   grant_rx, grant_tx;
   logic   wait_to;
   logic   resp_load;

   if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
      $error("conn_lookup_arb: TIMEOUT out of range 1..65535");
   end

`ifdef LOOKUP_TIMEOUT_EN
   localparam logic [15:0] TIMEOUT_L = 16'(TIMEOUT);
   logic [15:0] wait_cnt;
   logic        err_q;
   assign wait_to = (state == S_WAIT) && !eng_conn_valid && ((wait_cnt + 16'd1) == TIMEOUT_L);
`else
   assign wait_to = 1'b0;
`endif

   // last_grant = 1 means TX was served last, so RX wins the next tie
   assign grant_rx = (state == S_IDLE) && rx_tuple_valid && (!tx_tuple_valid || last_grant);
   assign grant_tx = (state == S_IDLE) && tx_tuple_valid && (!rx_tuple_valid || !last_grant);
   assign rx_tuple_ready  = grant_rx;
   assign tx_tuple_ready  = grant_tx;
   assign eng_tuple_valid = (state == S_ISSUE);
   assign busy            = (state != S_IDLE);
   assign resp_load       = (state == S_WAIT) && (eng_conn_valid || wait_to);

   assign rx_conn_valid = (state == S_RESP) && !eng_sel;
   assign tx_conn_valid = (state == S_RESP) &&  eng_sel;
`ifdef LOOKUP_TIMEOUT_EN
   assign rx_conn_err = rx_conn_valid && err_q;
   assign tx_conn_err = tx_conn_valid && err_q;
`else
   assign rx_conn_err = 1'b0;
   assign tx_conn_err = 1'b0;
`endif

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (grant_rx || grant_tx) state_nxt = S_ISSUE;
         S_ISSUE: if (eng_tuple_ready) state_nxt = S_WAIT;
         S_WAIT:  if (resp_load) state_nxt = S_RESP;
         S_RESP:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state          <= S_IDLE;
         last_grant     <= 1'b1;
         eng_tuple_data <= '0;
         eng_sel        <= 1'b0;
         rx_conn_data   <= '0;
         tx_conn_data   <= '0;
`ifdef LOOKUP_TIMEOUT_EN
         wait_cnt       <= '0;
         err_q          <= 1'b0;
`endif
      end else begin
         state <= state_nxt;
         if (grant_rx || grant_tx) begin
            eng_tuple_data <= grant_tx ? tx_tuple_data : rx_tuple_data;
            eng_sel        <= grant_tx;
         end
         // a timeout returns all ones; an engine result in the same cycle wins
         if (resp_load) begin
            if (eng_sel) tx_conn_data <= eng_conn_valid ? eng_conn_data : '1;
            else         rx_conn_data <= eng_conn_valid ? eng_conn_data : '1;
         end
         if (state == S_RESP) last_grant <= eng_sel;
`ifdef LOOKUP_TIMEOUT_EN
         if (state == S_ISSUE)     wait_cnt <= '0;
         else if (state == S_WAIT) wait_cnt <= wait_cnt + 16'd1;
         if (resp_load) err_q <= !eng_conn_valid;
`endif
      end
   end

endmodule

// File: tb/tb_conn_lookup_arb.sv
// Directed self-checking bench for conn_lookup_arb; timeout scenario follows LOOKUP_TIMEOUT_EN.
module tb_conn_lookup_arb;
   localparam int TW = 128;
   localparam int CW = 16;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [TW-1:0] rx_tuple_data, tx_tuple_data, eng_tuple_data;
   logic          rx_tuple_valid, rx_tuple_ready, tx_tuple_valid, tx_tuple_ready;
   logic [CW-1:0] rx_conn_data, tx_conn_data, eng_conn_data;
   logic          rx_conn_valid, rx_conn_err, tx_conn_valid, tx_conn_err;
   logic          eng_sel, eng_tuple_valid, eng_tuple_ready, eng_conn_valid, busy;

   int errors = 0;
   int checks = 0;

   conn_lookup_arb #(.TUPLE_W(TW), .CONN_W(CW), .TIMEOUT(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .rx_tuple_data(rx_tuple_data), .rx_tuple_valid(rx_tuple_valid), .rx_tuple_ready(rx_tuple_ready),
      .rx_conn_data(rx_conn_data), .rx_conn_valid(rx_conn_valid), .rx_conn_err(rx_conn_err),
      .tx_tuple_data(tx_tuple_data), .tx_tuple_valid(tx_tuple_valid), .tx_tuple_ready(tx_tuple_ready),
      .tx_conn_data(tx_conn_data), .tx_conn_valid(tx_conn_valid), .tx_conn_err(tx_conn_err),
      .eng_tuple_data(eng_tuple_data), .eng_sel(eng_sel), .eng_tuple_valid(eng_tuple_valid),
      .eng_tuple_ready(eng_tuple_ready), .eng_conn_data(eng_conn_data), .eng_conn_valid(eng_conn_valid),
      .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // from ISSUE with engine ready high: go to WAIT, return result, land in RESP
   task automatic finish_lookup(input logic [CW-1:0] res);
      tick();
      eng_conn_valid = 1'b1;
      eng_conn_data  = res;
      tick();
      eng_conn_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick();
      tick();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if ({rx_tuple_ready, tx_tuple_ready, eng_tuple_valid, eng_sel} !== 4'b0000) begin
         errors++; $display("FAIL reset_ctl got=%b exp=0000", {rx_tuple_ready, tx_tuple_ready, eng_tuple_valid, eng_sel}); end
      checks++; if ({rx_conn_valid, rx_conn_err, tx_conn_valid, tx_conn_err} !== 4'b0000) begin
         errors++; $display("FAIL reset_resp got=%b exp=0000", {rx_conn_valid, rx_conn_err, tx_conn_valid, tx_conn_err}); end
      checks++; if ({rx_conn_data, tx_conn_data} !== 32'h0) begin
         errors++; $display("FAIL reset_data got=%h exp=0", {rx_conn_data, tx_conn_data}); end
      checks++; if (eng_tuple_data !== '0) begin errors++; $display("FAIL reset_eng_data got=%h exp=0", eng_tuple_data); end
      rst_n = 1'b1;
   endtask

   task automatic test_rx_single();
      rx_tuple_data = 128'h0A0B; rx_tuple_valid = 1'b1; eng_tuple_ready = 1'b1;
      #1;
      checks++; if ({rx_tuple_ready, tx_tuple_ready} !== 2'b10) begin
         errors++; $display("FAIL single_ready got=%b exp=10", {rx_tuple_ready, tx_tuple_ready}); end
      tick();
      rx_tuple_valid = 1'b0;
      checks++; if ({eng_tuple_valid, eng_sel, busy} !== 3'b101) begin
         errors++; $display("FAIL single_issue got=%b exp=101", {eng_tuple_valid, eng_sel, busy}); end
      checks++; if (eng_tuple_data !== 128'h0A0B) begin errors++; $display("FAIL single_eng_data got=%h exp=0a0b", eng_tuple_data); end
      tick();
      checks++; if ({eng_tuple_valid, busy} !== 2'b01) begin
         errors++; $display("FAIL single_wait got=%b exp=01", {eng_tuple_valid, busy}); end
      tick();
      eng_conn_valid = 1'b1; eng_conn_data = 16'h0005;
      checks++; if (rx_conn_valid !== 1'b0) begin errors++; $display("FAIL single_early got=%b exp=0", rx_conn_valid); end
      tick();
      eng_conn_valid = 1'b0; eng_conn_data = 16'h0;
      checks++; if ({rx_conn_valid, rx_conn_err, rx_conn_data} !== {2'b10, 16'h0005}) begin
         errors++; $display("FAIL single_resp got=%b/%b/%h exp=1/0/0005", rx_conn_valid, rx_conn_err, rx_conn_data); end
      checks++; if ({tx_conn_valid, tx_conn_err, tx_conn_data} !== 18'h0) begin
         errors++; $display("FAIL single_tx_quiet got=%b/%b/%h exp=0/0/0000", tx_conn_valid, tx_conn_err, tx_conn_data); end
      tick();
      checks++; if ({rx_conn_valid, busy, rx_conn_data} !== {2'b00, 16'h0005}) begin
         errors++; $display("FAIL single_after got=%b/%b/%h exp=0/0/0005", rx_conn_valid, busy, rx_conn_data); end
   endtask

   task automatic test_fairness();
      rst_n = 1'b0; tick(); rst_n = 1'b1;
      rx_tuple_data = 128'h11; rx_tuple_valid = 1'b1;
      tx_tuple_data = 128'h22; tx_tuple_valid = 1'b1;
      eng_tuple_ready = 1'b1;
      #1;
      checks++; if ({rx_tuple_ready, tx_tuple_ready} !== 2'b10) begin
         errors++; $display("FAIL fair_tie1 got=%b exp=10", {rx_tuple_ready, tx_tuple_ready}); end
      tick();
      rx_tuple_data = 128'h33;
      checks++; if ({eng_sel, eng_tuple_data} !== {1'b0, 128'h11}) begin
         errors++; $display("FAIL fair_issue1 got=%b/%h exp=0/11", eng_sel, eng_tuple_data); end
      checks++; if ({rx_tuple_ready, tx_tuple_ready} !== 2'b00) begin
         errors++; $display("FAIL fair_busy_ready got=%b exp=00", {rx_tuple_ready, tx_tuple_ready}); end
      finish_lookup(16'h0101);
      checks++; if ({rx_conn_valid, tx_conn_valid, rx_conn_data} !== {2'b10, 16'h0101}) begin
         errors++; $display("FAIL fair_resp1 got=%b/%b/%h exp=1/0/0101", rx_conn_valid, tx_conn_valid, rx_conn_data); end
      tick();
      checks++; if ({rx_tuple_ready, tx_tuple_ready} !== 2'b01) begin
         errors++; $display("FAIL fair_tie2 got=%b exp=01", {rx_tuple_ready, tx_tuple_ready}); end
      tick();
      tx_tuple_valid = 1'b0;
      checks++; if ({eng_sel, eng_tuple_data} !== {1'b1, 128'h22}) begin
         errors++; $display("FAIL fair_issue2 got=%b/%h exp=1/22", eng_sel, eng_tuple_data); end
      finish_lookup(16'h0202);
      checks++; if ({tx_conn_valid, rx_conn_valid, tx_conn_data, rx_conn_data} !== {2'b10, 16'h0202, 16'h0101}) begin
         errors++; $display("FAIL fair_resp2 got=%b/%b/%h/%h exp=1/0/0202/0101", tx_conn_valid, rx_conn_valid, tx_conn_data, rx_conn_data); end
      tick();
      tx_tuple_valid = 1'b1;
      #1;
      checks++; if ({rx_tuple_ready, tx_tuple_ready} !== 2'b10) begin
         errors++; $display("FAIL fair_tie3 got=%b exp=10", {rx_tuple_ready, tx_tuple_ready}); end
      tick();
      rx_tuple_valid = 1'b0; tx_tuple_valid = 1'b0;
      checks++; if ({eng_sel, eng_tuple_data} !== {1'b0, 128'h33}) begin
         errors++; $display("FAIL fair_issue3 got=%b/%h exp=0/33", eng_sel, eng_tuple_data); end
      finish_lookup(16'h0303);
      tick();
   endtask

   task automatic test_stall();
      rx_tuple_data = 128'hBEEF; rx_tuple_valid = 1'b1; eng_tuple_ready = 1'b0;
      tick();
      rx_tuple_valid = 1'b0;
      tx_tuple_data = 128'h44; tx_tuple_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         checks++; if ({eng_tuple_valid, eng_sel, rx_tuple_ready, tx_tuple_ready, busy} !== 5'b10001 ||
                       eng_tuple_data !== 128'hBEEF) begin
            errors++; $display("FAIL stall_hold cyc=%0d got=%b/%h exp=10001/beef", i,
               {eng_tuple_valid, eng_sel, rx_tuple_ready, tx_tuple_ready, busy}, eng_tuple_data); end
         tick();
      end
      tx_tuple_valid = 1'b0; eng_tuple_ready = 1'b1;
      checks++; if ({eng_tuple_valid, eng_tuple_data} !== {1'b1, 128'hBEEF}) begin
         errors++; $display("FAIL stall_last got=%b/%h exp=1/beef", eng_tuple_valid, eng_tuple_data); end
      tick();
      checks++; if (eng_tuple_valid !== 1'b0) begin errors++; $display("FAIL stall_release got=%b exp=0", eng_tuple_valid); end
      eng_conn_valid = 1'b1; eng_conn_data = 16'h0BEE;
      tick();
      eng_conn_valid = 1'b0;
      checks++; if ({rx_conn_valid, rx_conn_data} !== {1'b1, 16'h0BEE}) begin
         errors++; $display("FAIL stall_resp got=%b/%h exp=1/0bee", rx_conn_valid, rx_conn_data); end
      tick();
   endtask

   task automatic test_spurious();
      eng_conn_valid = 1'b1; eng_conn_data = 16'h7777;
      tick();
      eng_conn_valid = 1'b0;
      checks++; if ({rx_conn_valid, tx_conn_valid, busy, eng_tuple_valid} !== 4'b0000 || rx_conn_data !== 16'h0BEE) begin
         errors++; $display("FAIL spurious_idle got=%b/%h exp=0000/0bee",
            {rx_conn_valid, tx_conn_valid, busy, eng_tuple_valid}, rx_conn_data); end
      tick();
      checks++; if ({rx_conn_valid, tx_conn_valid, busy} !== 3'b000) begin
         errors++; $display("FAIL spurious_after got=%b exp=000", {rx_conn_valid, tx_conn_valid, busy}); end
   endtask

   task automatic test_reset_in_wait();
      rx_tuple_data = 128'h66; rx_tuple_valid = 1'b1; eng_tuple_ready = 1'b1;
      tick();
      rx_tuple_valid = 1'b0;
      tick();
      checks++; if ({busy, eng_tuple_valid} !== 2'b10) begin
         errors++; $display("FAIL rstwait_in_wait got=%b exp=10", {busy, eng_tuple_valid}); end
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      checks++; if ({busy, eng_tuple_valid, rx_conn_data} !== {2'b00, 16'h0}) begin
         errors++; $display("FAIL rstwait_idle got=%b/%b/%h exp=0/0/0000", busy, eng_tuple_valid, rx_conn_data); end
      eng_conn_valid = 1'b1; eng_conn_data = 16'h0999;
      tick();
      eng_conn_valid = 1'b0;
      checks++; if ({rx_conn_valid, tx_conn_valid, busy} !== 3'b000) begin
         errors++; $display("FAIL rstwait_stale got=%b exp=000", {rx_conn_valid, tx_conn_valid, busy}); end
      rx_tuple_data = 128'h55; rx_tuple_valid = 1'b1;
      #1;
      checks++; if (rx_tuple_ready !== 1'b1) begin errors++; $display("FAIL rstwait_ready got=%b exp=1", rx_tuple_ready); end
      tick();
      rx_tuple_valid = 1'b0;
      finish_lookup(16'h0ABC);
      checks++; if ({rx_conn_valid, rx_conn_err, rx_conn_data} !== {2'b10, 16'h0ABC}) begin
         errors++; $display("FAIL rstwait_resp got=%b/%b/%h exp=1/0/0abc", rx_conn_valid, rx_conn_err, rx_conn_data); end
      tick();
   endtask

   task automatic test_timeout();
      tx_tuple_data = 128'h99; tx_tuple_valid = 1'b1; eng_tuple_ready = 1'b1;
      tick();
      tx_tuple_valid = 1'b0;
      tick();
`ifdef LOOKUP_TIMEOUT_EN
      for (int i = 0; i < 8; i++) begin
         checks++; if ({tx_conn_valid, busy} !== 2'b01) begin
            errors++; $display("FAIL timeout_wait cyc=%0d got=%b exp=01", i, {tx_conn_valid, busy}); end
         tick();
      end
      checks++; if ({tx_conn_valid, tx_conn_err, rx_conn_valid, tx_conn_data} !== {3'b110, 16'hFFFF}) begin
         errors++; $display("FAIL timeout_resp got=%b/%b/%b/%h exp=1/1/0/ffff", tx_conn_valid, tx_conn_err, rx_conn_valid, tx_conn_data); end
      tick();
      eng_conn_valid = 1'b1; eng_conn_data = 16'h0111;
      tick();
      eng_conn_valid = 1'b0;
      checks++; if ({tx_conn_valid, rx_conn_valid, busy} !== 3'b000) begin
         errors++; $display("FAIL timeout_late got=%b exp=000", {tx_conn_valid, rx_conn_valid, busy}); end
      tx_tuple_data = 128'hAA; tx_tuple_valid = 1'b1;
      #1;
      checks++; if (tx_tuple_ready !== 1'b1) begin errors++; $display("FAIL timeout_next_ready got=%b exp=1", tx_tuple_ready); end
      tick();
      tx_tuple_valid = 1'b0;
      finish_lookup(16'h1234);
`else
      for (int i = 0; i < 20; i++) begin
         checks++; if ({tx_conn_valid, busy} !== 2'b01) begin
            errors++; $display("FAIL notimeout_wait cyc=%0d got=%b exp=01", i, {tx_conn_valid, busy}); end
         tick();
      end
      eng_conn_valid = 1'b1; eng_conn_data = 16'h1234;
      tick();
      eng_conn_valid = 1'b0;
`endif
      checks++; if ({tx_conn_valid, tx_conn_err, tx_conn_data} !== {2'b10, 16'h1234}) begin
         errors++; $display("FAIL timeout_normal got=%b/%b/%h exp=1/0/1234", tx_conn_valid, tx_conn_err, tx_conn_data); end
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      rx_tuple_data = '0; rx_tuple_valid = 1'b0;
      tx_tuple_data = '0; tx_tuple_valid = 1'b0;
      eng_tuple_ready = 1'b0; eng_conn_data = '0; eng_conn_valid = 1'b0;
      test_reset();
      test_rx_single();
      test_fairness();
      test_stall();
      test_spurious();
      test_reset_in_wait();
      test_timeout();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/conn_lookup_arb.md
Name: conn_lookup_arb

Overview:
- Shares one connection-table lookup engine between two requesters: RX (inbound tuples) and TX (outbound tuples).
- Accepts one tuple at a time and forwards it to the engine with a side-select bit.
- Waits for the engine's connection index and returns it to the requester that issued the tuple.
- Sits between the header parsers and the hash connection table. Guarantees at most one lookup in flight and round-robin fairness between the two sides.

Parameters:
- TUPLE_W, 128, tuple bus width (5-tuple packed in the low 104 bits).
- CONN_W, 16, connection index width.
- TIMEOUT, 255, WAIT-state cycle limit; used only with LOOKUP_TIMEOUT_EN. Range 1..65535.

Ports:
- clk, input, 1, single clock; all logic on posedge.
- rst_n, input, 1, synchronous active-low reset.
- rx_tuple_data, input, TUPLE_W, RX lookup tuple.
- rx_tuple_valid, input, 1, RX tuple valid.
- rx_tuple_ready, output, 1, RX tuple accepted when valid&&ready.
- rx_conn_data, output, CONN_W, RX result index.
- rx_conn_valid, output, 1, one-cycle RX result strobe.
- rx_conn_err, output, 1, RX result error flag (qualified by rx_conn_valid).
- tx_tuple_data, input, TUPLE_W, TX lookup tuple.
- tx_tuple_valid, input, 1, TX tuple valid.
- tx_tuple_ready, output, 1, TX tuple accepted when valid&&ready.
- tx_conn_data, output, CONN_W, TX result index.
- tx_conn_valid, output, 1, one-cycle TX result strobe.
- tx_conn_err, output, 1, TX result error flag.
- eng_tuple_data, output, TUPLE_W, tuple presented to engine.
- eng_sel, output, 1, 0 = RX table search, 1 = TX table search.
- eng_tuple_valid, output, 1, engine request valid.
- eng_tuple_ready, input, 1, engine accepts request.
- eng_conn_data, input, CONN_W, engine result.
- eng_conn_valid, input, 1, engine result strobe.
- busy, output, 1, high in every state except IDLE.

Behaviour:
- Reset: synchronous on rst_n==0.
  - State=IDLE; all valid/ready/err outputs 0; data outputs 0; eng_sel=0; busy=0.
  - last_grant=TX, so RX wins the first tie.
  - Reset mid-operation abandons the in-flight lookup; no response is emitted for it.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - rx_tuple_ready/tx_tuple_ready are combinational; at most one is high.
  - Only one side valid: that side's ready=1.
  - Both valid: ready goes to the side not equal to last_grant.
  - On handshake: latch tuple into eng_tuple_data, set owner/eng_sel, go to ISSUE.
  - Ready is 0 in all other states.
- ISSUE:
  - eng_tuple_valid=1 with eng_tuple_data/eng_sel stable.
  - On eng_tuple_ready, deassert eng_tuple_valid next cycle and go to WAIT.
  - eng_tuple_ready may be held low indefinitely; data stays stable.
- WAIT:
  - On eng_conn_valid, latch eng_conn_data and go to RESP.
  - eng_conn_valid seen in IDLE/ISSUE/RESP is ignored.
- RESP:
  - Owner's conn_valid=1 for exactly one cycle with latched data; err=0. The other side's outputs stay 0.
  - last_grant<=owner; go to IDLE.
- Latency from handshake at cycle 0, with engine ready immediate and result at cycle k≥2: result strobe at cycle k+1. Minimum 3 cycles.
- Next accept is possible in the cycle after RESP.
- Back-to-back requests with both valid alternate RX, TX, RX, …
- The requester may drop valid before ready; no transfer occurs. Data is sampled only in the handshake cycle.
- conn_data outputs hold their last value between strobes.

Optional Feature:
LOOKUP_TIMEOUT_EN
- Defined:
  - A 16-bit counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT with no eng_conn_valid, go to RESP with conn_data=all ones and err=1.
  - A late engine result arriving afterwards is discarded. It is ignored in IDLE, or if it arrives in WAIT for a later lookup it is accepted as that lookup's result; no dedup is performed.
  - eng_conn_valid in the same cycle the counter hits TIMEOUT wins: normal response.
- Undefined: WAIT never times out; rx_conn_err/tx_conn_err tied 0; counter absent.

Test Plan:
- RX valid only, tuple 0x…0A0B, engine ready immediate, returns 0x0005 two cycles after issue → rx_conn_valid one cycle with 0x0005, err=0, eng_sel=0, tx outputs 0.
- RX and TX valid together from reset → RX granted first (eng_sel=0). After RX response, TX granted (eng_sel=1). Next tie again grants RX.
- eng_tuple_ready held low 10 cycles → eng_tuple_valid and data stable 11 cycles, both ready outputs 0, busy=1.
- Spurious eng_conn_valid in IDLE → no conn_valid on either side; state stays IDLE.
- rst_n low for one cycle while in WAIT → next cycle IDLE, busy=0. Subsequent engine result ignored; new RX request completes normally.
- LOOKUP_TIMEOUT_EN, TIMEOUT=8, engine never answers → tx_conn_valid with 0xFFFF and err=1, eight cycles after WAIT entry; next request serviced normally.
